// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encoding and the idle (released) level of the active-low button.
package button_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_debounce_if.sv
// Button-side signal bundle of the debouncer.
// master drives the raw pin; slave (the debouncer) returns level and strobes.
interface button_debounce_if;
  logic btn_raw_n;
  logic btn_n;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  modport master (
    output btn_raw_n,
    input  btn_n,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  btn_raw_n,
    output btn_n,
    output press_pulse,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Reset value is a parameter so idle-high and idle-low pins both fit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the async pin through two flops; only the second is used.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-FF sync, counter-qualified FSM, press/release strobes.
// Define BUTTON_LONG_PRESS_EN to build the hold counter and long_press strobe.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input  logic               clk,
  input  logic               reset,
  button_debounce_if.slave   btn
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s2;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  sync_2ff #(
    .RST_VAL (BTN_RELEASED)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn.btn_raw_n),
    .q_o   (s2)
  );

  // State, qualification counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      btn_q   <= BTN_RELEASED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Level change is accepted only after DEBOUNCE_CYCLES stable differing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      ST_RELEASED: begin
        if (!s2) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (s2) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          btn_d   = 1'b0;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (s2) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!s2) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          btn_d   = 1'b1;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn.btn_n         = btn_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = rel_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int            HW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold time since acceptance; survives aborted releases, saturates once.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d || rel_d) begin
      hold_d = '0;
    end else if ((state_q == ST_PRESSED || state_q == ST_WAIT_RELEASE)
                 && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
      long_d = (hold_q == HOLD_MAX - HW'(1));
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn.long_press = long_q;
`else
  assign btn.long_press = 1'b0 && (LONG_PRESS_CYCLES > 0);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: scenario tasks plus randomized run,
// checked against a run-length behavioural model of the debouncer.
module tb_button_debounce;

  localparam int N = 8;
  localparam int L = 32;
`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  button_debounce_if bif ();

  button_debounce #(
    .DEBOUNCE_CYCLES   (N),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  // Model: sync delay of two samples, then a level flips once the synced
  // value has disagreed with it for N consecutive cycles.
  logic m_s1, m_s2, m_deb, m_press, m_rel, m_long;
  int   m_run, m_hold;

  always @(posedge clk) begin
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1;
      m_run = 0; m_hold = 0;
    end else begin
      if (m_s2 != m_deb) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == N) begin
        m_deb = ~m_deb;
        m_run = 0;
        m_hold = 0;
        m_press = (m_deb == 1'b0);
        m_rel = (m_deb == 1'b1);
      end else if (LP_EN && m_deb == 1'b0 && m_hold < L) begin
        m_hold = m_hold + 1;
        m_long = (m_hold == L);
      end
      m_s2 = m_s1;
      m_s1 = bif.btn_raw_n;
    end
  end

  // Apply inputs sampled on the next edge, return after it at the negedge.
  task automatic drive(input logic r, input logic rs);
    bif.btn_raw_n = r;
    rst = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1);
      checks++;
      if ({bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press} !== 4'b1000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=1000", i,
          {bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press});
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (bif.btn_n !== (i < 10) || bif.press_pulse !== (i == 10)
          || bif.release_pulse !== 1'b0) begin
        failures++;
        $display("FAIL reset_press cyc=%0d got btn_n=%b press=%b rel=%b", i,
          bif.btn_n, bif.press_pulse, bif.release_pulse);
      end
    end
  endtask

  task automatic test_clean_press;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if ({bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press}
          !== {m_deb, m_press, m_rel, m_long}) begin
        failures++;
        $display("FAIL model_pre cyc=%0d got=%b exp=%b", i,
          {bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press},
          {m_deb, m_press, m_rel, m_long});
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (bif.btn_n !== (i < 10) || bif.press_pulse !== (i == 10)
          || bif.release_pulse !== 1'b0) begin
        failures++;
        $display("FAIL clean_press cyc=%0d got btn_n=%b press=%b rel=%b", i,
          bif.btn_n, bif.press_pulse, bif.release_pulse);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0);
      checks++;
      if (bif.btn_n !== (i >= 10) || bif.release_pulse !== (i == 10)
          || bif.press_pulse !== 1'b0) begin
        failures++;
        $display("FAIL clean_release cyc=%0d got btn_n=%b press=%b rel=%b", i,
          bif.btn_n, bif.press_pulse, bif.release_pulse);
      end
    end
  endtask

  task automatic test_bounce;
    int seg_len[6];
    logic seg_lvl[6];
    seg_len = '{3, 2, 5, 2, 7, 2};
    seg_lvl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < seg_len[s]; j++) begin
        drive(seg_lvl[s], 1'b0);
        checks++;
        if ({bif.btn_n, bif.press_pulse, bif.release_pulse} !== 3'b100) begin
          failures++;
          $display("FAIL bounce seg=%0d got=%b exp=100", s,
            {bif.btn_n, bif.press_pulse, bif.release_pulse});
        end
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (bif.btn_n !== (i < 10) || bif.press_pulse !== (i == 10)) begin
        failures++;
        $display("FAIL bounce_settle cyc=%0d got btn_n=%b press=%b", i,
          bif.btn_n, bif.press_pulse);
      end
    end
  endtask

  task automatic test_glitch_pressed;
    for (int i = 1; i <= 17; i++) begin
      drive((i <= 7), 1'b0);
      checks++;
      if (bif.btn_n !== 1'b0 || bif.release_pulse !== 1'b0) begin
        failures++;
        $display("FAIL glitch7 cyc=%0d got btn_n=%b rel=%b exp btn_n=0 rel=0", i,
          bif.btn_n, bif.release_pulse);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      drive((i <= 8), 1'b0);
      checks++;
      if (bif.btn_n !== (i >= 10 && i < 18) || bif.release_pulse !== (i == 10)
          || bif.press_pulse !== (i == 18)) begin
        failures++;
        $display("FAIL glitch8 cyc=%0d got btn_n=%b press=%b rel=%b", i,
          bif.btn_n, bif.press_pulse, bif.release_pulse);
      end
    end
  endtask

  task automatic test_reset_pressed;
    drive(1'b0, 1'b1);
    checks++;
    if ({bif.btn_n, bif.press_pulse, bif.release_pulse} !== 3'b100) begin
      failures++;
      $display("FAIL reset_pressed got=%b exp=100",
        {bif.btn_n, bif.press_pulse, bif.release_pulse});
    end
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b0);
      checks++;
      if (bif.btn_n !== (i < 10) || bif.press_pulse !== (i == 10)
          || bif.release_pulse !== 1'b0) begin
        failures++;
        $display("FAIL requalify cyc=%0d got btn_n=%b press=%b rel=%b", i,
          bif.btn_n, bif.press_pulse, bif.release_pulse);
      end
    end
  endtask

  task automatic test_long_press;
    int nlong;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
    nlong = 0;
    for (int i = 1; i <= 50; i++) begin
      drive(1'b0, 1'b0);
      if (bif.long_press === 1'b1) nlong++;
      checks++;
      if (bif.long_press !== (LP_EN && i == 42) || bif.press_pulse !== (i == 10)) begin
        failures++;
        $display("FAIL long_hold cyc=%0d got long=%b press=%b", i,
          bif.long_press, bif.press_pulse);
      end
    end
    checks++;
    if (nlong !== (LP_EN ? 1 : 0)) begin
      failures++;
      $display("FAIL long_count got=%0d exp=%0d", nlong, LP_EN ? 1 : 0);
    end
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      drive((i >= 30), 1'b0);
      checks++;
      if (bif.long_press !== 1'b0 || bif.release_pulse !== (i == 39)) begin
        failures++;
        $display("FAIL long_short cyc=%0d got long=%b rel=%b", i,
          bif.long_press, bif.release_pulse);
      end
    end
  endtask

  task automatic test_random;
    logic lvl;
    int   len;
    for (int s = 0; s < 300; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 3) == 0) len = len + 30;
      for (int j = 0; j < len; j++) begin
        drive(lvl, ($urandom_range(0, 199) == 0));
        checks++;
        if ({bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press}
            !== {m_deb, m_press, m_rel, m_long}) begin
          failures++;
          $display("FAIL model_rand seg=%0d got=%b exp=%b", s,
            {bif.btn_n, bif.press_pulse, bif.release_pulse, bif.long_press},
            {m_deb, m_press, m_rel, m_long});
        end
      end
    end
  endtask

  initial begin
    bif.btn_raw_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_pressed();
    test_reset_pressed();
    test_long_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
